// File: rtl/ps2_pkg.sv
// Shared FSM state type and scan-code constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous show-ahead FIFO; head reads zero while empty.
module ps2_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The extra MSB distinguishes a full buffer from an empty one when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronisers, frame FSM with idle timeout, scan-code FIFO.
// Optional macro PS2_BREAK_FILTER_EN drops 0xF0 and the byte following it.
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       key_get,
    output logic       key_down,
    output logic [7:0] spec_key,
    output logic       frame_err,
    output logic       overflow
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    ps2_state_t state;
    ps2_state_t state_next;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_cnt_next;
    logic [7:0]    shift;
    logic [7:0]    shift_next;
    logic          parity;
    logic          parity_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;

    logic ps2_clk_meta;
    logic ps2_clk_sync;
    logic ps2_clk_prev;
    logic ps2_data_meta;
    logic ps2_data_sync;
    logic fall;

    logic frame_valid;
    logic push;
    logic pop;
    logic key_get_prev;
    logic fifo_empty;
    logic fifo_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps2_clk_meta  <= 1'b1;
            ps2_clk_sync  <= 1'b1;
            ps2_clk_prev  <= 1'b1;
            ps2_data_meta <= 1'b1;
            ps2_data_sync <= 1'b1;
            key_get_prev  <= 1'b0;
        end else begin
            ps2_clk_meta  <= ps2_clk;
            ps2_clk_sync  <= ps2_clk_meta;
            ps2_clk_prev  <= ps2_clk_sync;
            ps2_data_meta <= ps2_data;
            ps2_data_sync <= ps2_data_meta;
            key_get_prev  <= key_get;
        end
    end

    assign fall = ps2_clk_prev && !ps2_clk_sync;
    assign pop  = key_get && !key_get_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            parity  <= 1'b0;
            timer   <= '0;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
            shift   <= shift_next;
            parity  <= parity_next;
            timer   <= timer_next;
        end
    end

    // The timer only runs mid-frame and restarts on every falling edge.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shift_next   = shift;
        parity_next  = parity;
        timer_next   = '0;
        frame_valid  = 1'b0;
        frame_err    = 1'b0;
        if (state != IDLE && !fall) begin
            if (timer == TIMER_LAST) begin
                state_next = IDLE;
            end else begin
                timer_next = timer + TW'(1);
            end
        end
        if (fall) begin
            case (state)
                IDLE: begin
                    if (!ps2_data_sync) begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                    end
                end
                DATA: begin
                    shift_next   = {ps2_data_sync, shift[7:1]};
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_next = PARITY;
                    end
                end
                PARITY: begin
                    parity_next = ps2_data_sync;
                    state_next  = STOP;
                end
                STOP: begin
                    state_next = IDLE;
                    if (ps2_data_sync && (^{shift, parity})) begin
                        frame_valid = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

`ifdef PS2_BREAK_FILTER_EN
    logic break_pending;

    // A pending break swallows exactly one following valid byte, whatever it is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            break_pending <= 1'b0;
        end else if (frame_valid) begin
            if (break_pending) begin
                break_pending <= 1'b0;
            end else if (shift == PS2_BREAK) begin
                break_pending <= 1'b1;
            end
        end
    end

    assign push = frame_valid && !break_pending && (shift != PS2_BREAK);
`else
    assign push = frame_valid;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    assign key_down = !fifo_empty;

    ps2_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(shift),
        .pop      (pop),
        .head     (spec_key),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

endmodule

// File: tb/tb_ps2_keyboard.sv
// Self-checking bench for ps2_keyboard against a queue-based scan-code model.
module tb_ps2_keyboard;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 200;
    localparam int HALF    = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       key_get;
    logic       key_down;
    logic [7:0] spec_key;
    logic       frame_err;
    logic       overflow;

    int checks   = 0;
    int failures = 0;
    int err_seen = 0;

    logic [7:0] model_q[$];
    bit         model_ovf;
    bit         model_pending;

    ps2_keyboard #(
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .key_get  (key_get),
        .key_down (key_down),
        .spec_key (spec_key),
        .frame_err(frame_err),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) err_seen++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Model of a correctly received byte: optional break filter, then bounded queue.
    function automatic void model_frame(input logic [7:0] b);
`ifdef PS2_BREAK_FILTER_EN
        if (model_pending) begin
            model_pending = 1'b0;
            return;
        end
        if (b == 8'hF0) begin
            model_pending = 1'b1;
            return;
        end
`endif
        if (model_q.size() < DEPTH) model_q.push_back(b);
        else model_ovf = 1'b1;
    endfunction

    function automatic logic [7:0] model_head();
        return (model_q.size() > 0) ? model_q[0] : 8'h00;
    endfunction

    task automatic ps2_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop_bit);
        logic par;
        par = (~^b) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(stop_bit);
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        if (!bad_par && stop_bit) model_frame(b);
    endtask

    task automatic pop_key();
        @(negedge clk) key_get = 1'b1;
        @(negedge clk) key_get = 1'b0;
        if (model_q.size() > 0) void'(model_q.pop_front());
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        key_get  = 1'b0;
        repeat (4) @(negedge clk);
        model_q.delete();
        model_ovf     = 1'b0;
        model_pending = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        key_get  = 1'b0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (key_down !== 1'b0) begin failures++; $display("[TB] FAIL reset_key_down: got %b expected 0", key_down); end
        if (spec_key !== 8'h00) begin failures++; $display("[TB] FAIL reset_spec_key: got %h expected 00", spec_key); end
        if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
        if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
        do_reset();
    endtask

    task automatic test_single_frame();
        do_reset();
        send_frame(8'h1C, 1'b0, 1'b1);
        checks += 4;
        if (key_down !== 1'b1) begin failures++; $display("[TB] FAIL single_key_down: got %b expected 1", key_down); end
        if (spec_key !== 8'h1C) begin failures++; $display("[TB] FAIL single_spec_key: got %h expected 1c", spec_key); end
        pop_key();
        if (key_down !== 1'b0) begin failures++; $display("[TB] FAIL single_pop_key_down: got %b expected 0", key_down); end
        if (spec_key !== 8'h00) begin failures++; $display("[TB] FAIL single_pop_spec_key: got %h expected 00", spec_key); end
    endtask

    task automatic test_frame_errors();
        int e0;
        do_reset();
        e0 = err_seen;
        send_frame(8'h1C, 1'b1, 1'b1);
        checks += 4;
        if (err_seen - e0 !== 1) begin failures++; $display("[TB] FAIL parity_err_pulses: got %0d expected 1", err_seen - e0); end
        if (key_down !== 1'b0) begin failures++; $display("[TB] FAIL parity_key_down: got %b expected 0", key_down); end
        send_frame(8'h55, 1'b0, 1'b0);
        if (err_seen - e0 !== 2) begin failures++; $display("[TB] FAIL stop_err_pulses: got %0d expected 2", err_seen - e0); end
        if (key_down !== 1'b0) begin failures++; $display("[TB] FAIL stop_key_down: got %b expected 0", key_down); end
    endtask

    task automatic test_break_filter();
        logic [7:0] expect_q[$];
        do_reset();
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        send_frame(8'h32, 1'b0, 1'b1);
        send_frame(8'hE0, 1'b0, 1'b1);
`ifdef PS2_BREAK_FILTER_EN
        expect_q = '{8'h32, 8'hE0};
`else
        expect_q = '{8'hF0, 8'h1C, 8'h32, 8'hE0};
`endif
        foreach (expect_q[i]) begin
            checks += 2;
            if (key_down !== 1'b1) begin failures++; $display("[TB] FAIL break_key_down[%0d]: got %b expected 1", i, key_down); end
            if (spec_key !== expect_q[i]) begin failures++; $display("[TB] FAIL break_byte[%0d]: got %h expected %h", i, spec_key, expect_q[i]); end
            pop_key();
        end
        checks++;
        if (key_down !== 1'b0) begin failures++; $display("[TB] FAIL break_drained: got %b expected 0", key_down); end
    endtask

    task automatic test_timeout();
        int e0;
        do_reset();
        e0 = err_seen;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (TIMEOUT + 20) @(negedge clk);
        send_frame(8'h2A, 1'b0, 1'b1);
        checks += 4;
        if (key_down !== 1'b1) begin failures++; $display("[TB] FAIL timeout_key_down: got %b expected 1", key_down); end
        if (spec_key !== 8'h2A) begin failures++; $display("[TB] FAIL timeout_spec_key: got %h expected 2a", spec_key); end
        pop_key();
        if (key_down !== 1'b0) begin failures++; $display("[TB] FAIL timeout_single_byte: got %b expected 0", key_down); end
        if (err_seen !== e0) begin failures++; $display("[TB] FAIL timeout_no_err: got %0d expected %0d", err_seen, e0); end
    endtask

    task automatic test_hold_pop();
        do_reset();
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        @(negedge clk) key_get = 1'b1;
        repeat (5) @(negedge clk);
        key_get = 1'b0;
        void'(model_q.pop_front());
        repeat (2) @(negedge clk);
        checks += 2;
        if (key_down !== 1'b1) begin failures++; $display("[TB] FAIL hold_key_down: got %b expected 1", key_down); end
        if (spec_key !== 8'h22) begin failures++; $display("[TB] FAIL hold_spec_key: got %h expected 22", spec_key); end
    endtask

    task automatic test_random();
        int e0;
        int exp_err;
        int r;
        logic [7:0] b;
        do_reset();
        e0 = err_seen;
        exp_err = 0;
        for (int it = 0; it < 25; it++) begin
            r = $urandom_range(0, 9);
            b = 8'($urandom);
            if (r < 7) send_frame(b, 1'b0, 1'b1);
            else if (r == 7) begin send_frame(b, 1'b1, 1'b1); exp_err++; end
            else begin send_frame(b, 1'b0, 1'b0); exp_err++; end
            if ($urandom_range(0, 2) == 0) pop_key();
            checks += 4;
            if (key_down !== (model_q.size() > 0)) begin failures++; $display("[TB] FAIL rand_key_down[%0d]: got %b expected %b", it, key_down, model_q.size() > 0); end
            if (spec_key !== model_head()) begin failures++; $display("[TB] FAIL rand_spec_key[%0d]: got %h expected %h", it, spec_key, model_head()); end
            if (overflow !== model_ovf) begin failures++; $display("[TB] FAIL rand_overflow[%0d]: got %b expected %b", it, overflow, model_ovf); end
            if (err_seen - e0 !== exp_err) begin failures++; $display("[TB] FAIL rand_err[%0d]: got %0d expected %0d", it, err_seen - e0, exp_err); end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_flag: got %b expected 1", overflow); end
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (spec_key !== 8'(i)) begin failures++; $display("[TB] FAIL ovf_order[%0d]: got %h expected %h", i, spec_key, 8'(i)); end
            pop_key();
        end
        checks += 2;
        if (key_down !== 1'b0) begin failures++; $display("[TB] FAIL ovf_drained: got %b expected 0", key_down); end
        if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_reset_mid_frame();
        int e0;
        do_reset();
        send_frame(8'h77, 1'b0, 1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        checks += 4;
        if (key_down !== 1'b0) begin failures++; $display("[TB] FAIL midrst_key_down: got %b expected 0", key_down); end
        if (spec_key !== 8'h00) begin failures++; $display("[TB] FAIL midrst_spec_key: got %h expected 00", spec_key); end
        if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL midrst_overflow: got %b expected 0", overflow); end
        if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL midrst_frame_err: got %b expected 0", frame_err); end
        model_q.delete();
        model_ovf     = 1'b0;
        model_pending = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        e0 = err_seen;
        send_frame(8'h55, 1'b0, 1'b1);
        checks += 3;
        if (key_down !== 1'b1) begin failures++; $display("[TB] FAIL midrst_after_key_down: got %b expected 1", key_down); end
        if (spec_key !== 8'h55) begin failures++; $display("[TB] FAIL midrst_after_spec_key: got %h expected 55", spec_key); end
        if (err_seen !== e0) begin failures++; $display("[TB] FAIL midrst_after_err: got %0d expected %0d", err_seen, e0); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_frame_errors();
        test_break_filter();
        test_timeout();
        test_hold_pop();
        test_random();
        test_overflow();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
